dmem_responder: RTL and testbench

//  Data-memory responder for the CPU's DMEM interface, the target end of the core's load/store port.

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the CPU load/store port.
// Word-organised RAM with combinational read and synchronous full-word write.
// After reset a clear FSM zeroes the array while holding ready low. The CPU
// top level ORs ~ready into its halt, so the core stalls until the clear is done.
// Optional MMIO window (cycle counter, GPIO register, tohost halt request)
// is compiled in when the macro DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int         DEPTH_WORDS    = 1024,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] MMIO_BASE_HI   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_read_wrn,
  input  logic [15:0] dmem_address_bus,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        ready,
  output logic        halt_req,
  output logic [31:0] gpio_out,
  output logic [31:0] tohost_value
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e         state_q;
  logic [AW-1:0]  clr_idx_q;
  logic           ready_q;
  logic [31:0]    mem [DEPTH_WORDS];

  // Word index: byte-offset bits dropped, bits above the RAM size dropped,
  // so the RAM aliases every DEPTH_WORDS*4 bytes.
  logic [AW-1:0]  idx;
  assign idx = dmem_address_bus[AW+1:2];

  logic mmio_sel;
  logic ram_we;

  // Clear/run sequencer; RUN is terminal until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ready_q   <= !CLEAR_ON_RESET;
      clr_idx_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_idx_q <= clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  assign ready = ready_q;

  // CPU stores reach the RAM only in RUN and only outside the MMIO window.
  assign ram_we = ready_q && !dmem_read_wrn && !mmio_sel;

  // RAM array: deliberately no reset. While rst_n is held, clr_idx stays 0
  // and word 0 may be rewritten with zero, which the following clear
  // would do anyway.
  always_ff @(posedge clk) begin
    if (!ready_q)
      mem[clr_idx_q] <= '0;
    else if (ram_we)
      mem[idx] <= dmem_wdata;
  end

`ifdef DMEM_MMIO_EN
  // Word offset inside the 256-byte MMIO page; byte-offset bits ignored.
  logic [5:0]  mmio_off;
  logic        mmio_we;
  logic [31:0] cycle_cnt_q;
  logic [31:0] gpio_q;
  logic [31:0] tohost_q;
  logic        halt_q;

  assign mmio_sel = (dmem_address_bus[15:8] == MMIO_BASE_HI);
  assign mmio_off = dmem_address_bus[7:2];
  assign mmio_we  = ready_q && !dmem_read_wrn && mmio_sel;

  // Free-running cycle counter, counts only once the memory is usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt_q <= '0;
    else if (ready_q)
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  // MMIO store side: GPIO register and tohost with sticky halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q   <= '0;
      tohost_q <= '0;
      halt_q   <= 1'b0;
    end else if (mmio_we) begin
      case (mmio_off)
        6'd1: gpio_q <= dmem_wdata;
        6'd2: begin
          tohost_q <= dmem_wdata;
          if (dmem_wdata != 32'd0)
            halt_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gpio_out     = gpio_q;
  assign tohost_value = tohost_q;
  assign halt_req     = halt_q;

  // Load data: zero during clear and on write cycles, MMIO or RAM otherwise.
  always_comb begin
    dmem_rdata = '0;
    if (ready_q && dmem_read_wrn) begin
      if (mmio_sel) begin
        case (mmio_off)
          6'd0:    dmem_rdata = cycle_cnt_q;
          6'd1:    dmem_rdata = gpio_q;
          6'd2:    dmem_rdata = tohost_q;
          default: dmem_rdata = '0;
        endcase
      end else begin
        dmem_rdata = mem[idx];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{dmem_address_bus};
`else
  assign mmio_sel     = 1'b0;
  assign gpio_out     = '0;
  assign tohost_value = '0;
  assign halt_req     = 1'b0;

  // Load data: zero during clear and on write cycles, RAM otherwise.
  always_comb begin
    dmem_rdata = '0;
    if (ready_q && dmem_read_wrn)
      dmem_rdata = mem[idx];
  end

  // Address bits outside the index and the unused window base are dropped.
  logic unused_bits;
  assign unused_bits = ^{dmem_address_bus, MMIO_BASE_HI};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at DEPTH_WORDS=16 with the clear FSM enabled.
// Random and directed accesses are compared with a word-array model that
// applies the addressing rules arithmetically: word = (addr / 4) mod 16.
module tb_dmem_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_read_wrn = 1'b1;
  logic [15:0] dmem_address_bus = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        ready;
  logic        halt_req;
  logic [31:0] gpio_out;
  logic [31:0] tohost_value;

  int vec  = 0;
  int miss = 0;

  logic [31:0] mdl [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS    (DEPTH),
    .CLEAR_ON_RESET (1'b1),
    .MMIO_BASE_HI   (8'hFF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dmem_read_wrn    (dmem_read_wrn),
    .dmem_address_bus (dmem_address_bus),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .ready            (ready),
    .halt_req         (halt_req),
    .gpio_out         (gpio_out),
    .tohost_value     (tohost_value)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  function automatic bit is_mmio(input logic [15:0] a);
`ifdef DMEM_MMIO_EN
    return (int'(a) / 256) == 255;
`else
    return 1'b0;
`endif
  endfunction

  // One write cycle: inputs held across a single posedge, then bus idles.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    dmem_read_wrn    = 1'b0;
    dmem_address_bus = a;
    dmem_wdata       = d;
    @(posedge clk); #1;
    dmem_read_wrn    = 1'b1;
    dmem_address_bus = '0;
    dmem_wdata       = '0;
  endtask

  // One read cycle: data sampled in the same cycle the address is presented.
  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    dmem_read_wrn    = 1'b1;
    dmem_address_bus = a;
    #1;
    d = dmem_rdata;
    @(posedge clk); #1;
    dmem_address_bus = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // Reset pulse; released on a falling edge so the next rising edge is clear edge 1.
  task automatic reset_dut();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (ready !== 1'b1) begin
      miss++;
      $display("FAIL %s: ready timeout got %b want 1", nm, ready);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    vec++;
    if ({ready, halt_req, gpio_out, tohost_value} !== 66'd0) begin
      miss++;
      $display("FAIL reset_vals: rdy=%b halt=%b gpio=%h tohost=%h want all 0",
               ready, halt_req, gpio_out, tohost_value);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= DEPTH; n++) begin
      @(posedge clk); #1;
      vec++;
      if (ready !== (n == DEPTH)) begin
        miss++;
        $display("FAIL clear_len1 edge %0d: ready=%b want %b", n, ready, n == DEPTH);
      end
    end
    // fill the whole array with ones, then reset and expect a full clear
    for (int i = 0; i < DEPTH; i++) wr(16'(i * 4), 32'hFFFF_FFFF);
    reset_dut();
    for (int n = 1; n <= DEPTH; n++) begin
      @(posedge clk); #1;
      vec++;
      if (ready !== (n == DEPTH)) begin
        miss++;
        $display("FAIL clear_len2 edge %0d: ready=%b want %b", n, ready, n == DEPTH);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(16'(i * 4), d);
      vec++;
      if (d !== 32'd0) begin
        miss++;
        $display("FAIL cleared @%h: got %h want 0", i * 4, d);
      end
    end
  endtask

  task automatic test_raw_same_cycle();
    logic [31:0] d;
    wr(16'h0010, 32'hDEAD_BEEF);
    mdl[widx(16'h0010)] = 32'hDEAD_BEEF;
    rd(16'h0010, d);
    vec++;
    if (d !== 32'hDEAD_BEEF) begin
      miss++; $display("FAIL raw @0010: got %h want deadbeef", d);
    end
    rd(16'h0012, d);
    vec++;
    if (d !== 32'hDEAD_BEEF) begin
      miss++; $display("FAIL raw @0012: got %h want deadbeef", d);
    end
    dmem_read_wrn = 1'b0; dmem_address_bus = 16'h0010; #1;
    vec++;
    if (dmem_rdata !== 32'd0) begin
      miss++; $display("FAIL rdata_on_write: got %h want 0", dmem_rdata);
    end
    dmem_read_wrn = 1'b1; dmem_address_bus = '0;
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr(16'h0040, 32'h0000_0011);
    mdl[widx(16'h0040)] = 32'h11;
    rd(16'h0000, d);
    vec++;
    if (d !== 32'h0000_0011) begin
      miss++; $display("FAIL wrap @0000: got %h want 00000011", d);
    end
  endtask

  task automatic test_write_in_clear();
    logic [31:0] d;
    reset_dut();
    repeat (2) @(posedge clk);
    #1;
    dmem_read_wrn = 1'b1; dmem_address_bus = 16'h0004; #1;
    vec++;
    if (dmem_rdata !== 32'd0 || ready !== 1'b0) begin
      miss++; $display("FAIL clear_read: rdata=%h ready=%b want 0/0", dmem_rdata, ready);
    end
    dmem_address_bus = '0;
    wr(16'h0020, 32'h1234_5678);
    wait_ready("clear_write");
    rd(16'h0020, d);
    vec++;
    if (d !== 32'd0) begin
      miss++; $display("FAIL clear_write @0020: got %h want 0", d);
    end
  endtask

  task automatic test_reset_mid_clear();
    reset_dut();
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (ready !== 1'b0) begin
      miss++; $display("FAIL midclr_rst: ready=%b want 0", ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int n = 1; n <= DEPTH; n++) begin
      @(posedge clk); #1;
      vec++;
      if (ready !== (n == DEPTH)) begin
        miss++;
        $display("FAIL midclr_len edge %0d: ready=%b want %b", n, ready, n == DEPTH);
      end
    end
  endtask

  task automatic test_mmio();
    logic [31:0] d, c0, c1;
`ifdef DMEM_MMIO_EN
    wr(16'hFF04, 32'h0000_00A5);
    vec++;
    if (gpio_out !== 32'hA5) begin
      miss++; $display("FAIL gpio_out: got %h want 000000a5", gpio_out);
    end
    rd(16'hFF04, d);
    vec++;
    if (d !== 32'hA5) begin
      miss++; $display("FAIL gpio_rd: got %h want 000000a5", d);
    end
    rd(16'hFF00, c0);
    repeat (4) @(posedge clk);
    #1;
    rd(16'hFF00, c1);
    vec++;
    if (c1 - c0 !== 32'd5) begin
      miss++; $display("FAIL cycle_cnt: delta %0d want 5", c1 - c0);
    end
    wr(16'hFF08, 32'd1);
    vec++;
    if (halt_req !== 1'b1 || tohost_value !== 32'd1) begin
      miss++; $display("FAIL tohost1: halt=%b val=%h want 1/1", halt_req, tohost_value);
    end
    wr(16'hFF08, 32'd0);
    wr(16'hFF08, 32'd0);
    vec++;
    if (halt_req !== 1'b1 || tohost_value !== 32'd0) begin
      miss++; $display("FAIL tohost0: halt=%b val=%h want 1/0", halt_req, tohost_value);
    end
    wr(16'hFF10, 32'hCAFE_F00D);
    rd(16'hFF10, d);
    vec++;
    if (d !== 32'd0) begin
      miss++; $display("FAIL mmio_other: got %h want 0", d);
    end
    rd(16'h0008, d);
    vec++;
    if (d !== mdl[2]) begin
      miss++; $display("FAIL mmio_no_ram: got %h want %h", d, mdl[2]);
    end
`else
    c0 = '0; c1 = '0;
    wr(16'hFF08, 32'd1);
    mdl[widx(16'hFF08)] = 32'd1;
    rd(16'h0008, d);
    vec++;
    if (d !== 32'd1) begin
      miss++; $display("FAIL nommio_ram: got %h want 1", d);
    end
    vec++;
    if (halt_req !== 1'b0 || tohost_value !== 32'd0 || gpio_out !== 32'd0) begin
      miss++; $display("FAIL nommio_outs: halt=%b tohost=%h gpio=%h want 0", halt_req, tohost_value, gpio_out);
    end
    if (c0 != c1) $display("note: counters unused");
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, w;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(16'h7FFF, 0));
      w = $urandom;
      wr(a, w);
      mdl[widx(a)] = w;
      // alias: same word index, different byte offset and upper bits
      b = 16'((int'(a) % 64) / 4 * 4 + $urandom_range(3, 0) + 64 * $urandom_range(500, 0));
      rd(b, d);
      vec++;
      if (d !== w) begin
        miss++; $display("FAIL b2b %0d wr@%h rd@%h: got %h want %h", i, a, b, d, w);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, w;
    logic [15:0] a;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom_range(16'hFEFF, 0));
      if (is_mmio(a)) a = 16'h0000;
      if ($urandom_range(1, 0) == 0) begin
        w = $urandom;
        wr(a, w);
        mdl[widx(a)] = w;
      end else begin
        rd(a, d);
        vec++;
        if (d !== mdl[widx(a)]) begin
          miss++; $display("FAIL rand %0d rd@%h: got %h want %h", i, a, d, mdl[widx(a)]);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_raw_same_cycle();
    test_wrap();
    test_write_in_clear();
    test_reset_mid_clear();
    test_mmio();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
